// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier, with a start/busy/done handshake for stalling.
// Ports: clk, reset (async, active-high), start, ALUControl[5:0], Shamt,
//   A/B[WIDTH-1:0], sa[4:0] in; result[WIDTH-1:0], zero, busy, done,
//   illegal out (all registered).
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       ALUControl,
    input  logic             Shamt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       sa,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_SUB  = 6'b001010;
    localparam logic [5:0] OP_SLT  = 6'b001011;
    localparam logic [5:0] OP_ANDN = 6'b001000;
    localparam logic [5:0] OP_ORN  = 6'b001001;
    localparam logic [5:0] OP_NOT  = 6'b000100;
    localparam logic [5:0] OP_XOR  = 6'b000101;
    localparam logic [5:0] OP_SLL  = 6'b000111;
    localparam logic [5:0] OP_SRL  = 6'b010111;
    localparam logic [5:0] OP_SRA  = 6'b100111;
    localparam logic [5:0] OP_MUL  = 6'b000110;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic [WIDTH-1:0] acc_nxt;

    // Single-cycle datapath
    always_comb begin
        shamt   = Shamt ? SW'(sa) : B[SW-1:0];
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (ALUControl)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(A) < $signed(B)};
            OP_ANDN: alu_res = A & ~B;
            OP_ORN:  alu_res = A | ~B;
            OP_NOT:  alu_res = ~A;
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = B << shamt;
            OP_SRL:  alu_res = B >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(B) >>> shamt);
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state logic; multiplier retires one multiplier bit per cycle
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                        done_d    = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                // Last bit folds straight into the result
                if (cnt_q == SW'(WIDTH - 1)) begin
                    result_d  = acc_nxt;
                    zero_d    = (acc_nxt == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, multiplier corner
// sequences and randomized ops against a behavioural reference.
module tb_alu_exec_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  ALUControl;
    logic        Shamt;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  sa;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        illegal;

    int total  = 0;
    int passed = 0;
    logic [31:0] last_res = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ALUControl(ALUControl), .Shamt(Shamt),
        .A(A), .B(B), .sa(sa),
        .result(result), .zero(zero), .busy(busy),
        .done(done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  code;
        logic        sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        logic [31:0] exp;
        logic        il;
        string       nm;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: plain arithmetic on the op-code table
    function automatic void ref_op(input logic [5:0] c, input logic sh,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] s5,
                                   output logic [31:0] r, output logic il);
        int s;
        s  = sh ? int'(s5) : int'(b % 32);
        il = 1'b0;
        case (c)
            6'b000000: r = a & b;
            6'b000001: r = a | b;
            6'b000010: r = a + b;
            6'b001010: r = a - b;
            6'b001011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'b001000: r = a & ~b;
            6'b001001: r = a | ~b;
            6'b000100: r = ~a;
            6'b000101: r = a ^ b;
            6'b000111: r = b << s;
            6'b010111: r = b >> s;
            6'b100111: r = $signed(b) >>> s;
            6'b000110: r = a * b;
            default: begin r = 32'd0; il = 1'b1; end
        endcase
    endfunction

    task automatic single(input logic [5:0] code, input logic sh,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s, input logic [31:0] er,
                          input logic eil, input string nm);
        @(negedge clk);
        ALUControl = code; Shamt = sh; A = a; B = b; sa = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " result"}, result, er);
        chk({nm, " zero"}, zero, (er == 32'd0));
        chk({nm, " done"}, done, 1'b1);
        chk({nm, " illegal"}, illegal, eil);
        last_res = er;
    endtask

    task automatic mul_seq(input logic [31:0] a, input logic [31:0] b,
                           input int inj, input string nm);
        int n;
        bit ok;
        logic [31:0] exp;
        logic il;
        ref_op(6'b000110, 1'b0, a, b, 5'd0, exp, il);
        @(negedge clk);
        ALUControl = 6'b000110; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " busy@start"}, busy, 1'b1);
        chk({nm, " done@start"}, done, 1'b0);
        chk({nm, " hold@start"}, result, last_res);
        n  = 0;
        ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            ALUControl = 6'b000101; A = $urandom; B = $urandom;
            if (c == inj) begin
                ALUControl = 6'b000010; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                n = c;
                break;
            end
            if (!busy || result !== last_res) ok = 1'b0;
        end
        chk({nm, " latency"}, n, 32);
        chk({nm, " busy/hold during"}, ok, 1'b1);
        chk({nm, " result"}, result, exp);
        chk({nm, " zero"}, zero, (exp == 32'd0));
        chk({nm, " illegal"}, illegal, 1'b0);
        chk({nm, " busy@done"}, busy, 1'b0);
        last_res = exp;
        @(posedge clk); #1;
        chk({nm, " done one pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [5:0] codes[15];
        logic [31:0] er;
        logic eil;
        int nd;

        codes = '{6'b000000, 6'b000001, 6'b000010, 6'b001010, 6'b001011,
                  6'b001000, 6'b001001, 6'b000100, 6'b000101, 6'b000111,
                  6'b010111, 6'b100111, 6'b000110, 6'b111111, 6'b110000};

        vecs[0]  = '{6'b000010, 1'b0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0, "add wrap"};
        vecs[1]  = '{6'b001010, 1'b0, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0, "sub"};
        vecs[2]  = '{6'b001011, 1'b0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, "slt neg"};
        vecs[3]  = '{6'b001011, 1'b0, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, "slt pos"};
        vecs[4]  = '{6'b100111, 1'b1, 32'h1234, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, "sra"};
        vecs[5]  = '{6'b010111, 1'b1, 32'h1234, 32'h80000000, 5'd4, 32'h08000000, 1'b0, "srl"};
        vecs[6]  = '{6'b000111, 1'b0, 32'h0, 32'h3, 5'd9, 32'h18, 1'b0, "sll B"};
        vecs[7]  = '{6'b000000, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, "and"};
        vecs[8]  = '{6'b000001, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0, "or"};
        vecs[9]  = '{6'b001000, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h00F000F0, 1'b0, "andn"};
        vecs[10] = '{6'b001001, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF0FFF0FF, 1'b0, "orn"};
        vecs[11] = '{6'b000100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0F0F0F0F, 1'b0, "not"};
        vecs[12] = '{6'b000101, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0, "xor"};
        vecs[13] = '{6'b111111, 1'b0, 32'h5, 32'h6, 5'd0, 32'h0, 1'b1, "illegal"};
        vecs[14] = '{6'b000010, 1'b0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, "add clears ill"};
        vecs[15] = '{6'b000111, 1'b1, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, "sll sa31"};

        reset = 1'b1; start = 1'b0; ALUControl = '0; Shamt = 1'b0;
        A = '0; B = '0; sa = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst result", result, 32'd0);
        chk("rst zero", zero, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst illegal", illegal, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table; consecutive starts also exercise back-to-back done
        foreach (vecs[i])
            single(vecs[i].code, vecs[i].sh, vecs[i].a, vecs[i].b,
                   vecs[i].s, vecs[i].exp, vecs[i].il, vecs[i].nm);

        @(posedge clk); #1;
        chk("idle done low", done, 1'b0);

        mul_seq(32'h00010001, 32'h00010001, 5, "mul ign start");
        single(6'b000010, 1'b0, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, "add after mul");
        mul_seq(32'hFFFFFFFF, 32'hFFFFFFFF, -1, "mul max");
        mul_seq(32'h0, 32'h12345678, -1, "mul zero");

        // Reset in the middle of a multiply
        @(negedge clk);
        ALUControl = 6'b000110; A = 32'd7; B = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst result", result, 32'd0);
        chk("midrst zero", zero, 1'b1);
        chk("midrst done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        last_res = 32'd0;
        nd = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("midrst no done", nd, 0);
        single(6'b000010, 1'b0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, "add post rst");

        // Randomized ops against the reference
        for (int k = 0; k < 40; k++) begin
            logic [5:0] c;
            logic [31:0] ra, rb;
            logic [4:0] rs;
            logic rsh;
            c   = codes[$urandom_range(14)];
            ra  = $urandom;
            rb  = $urandom;
            rs  = 5'($urandom);
            rsh = 1'($urandom);
            if (c == 6'b000110) begin
                mul_seq(ra, rb, -1, "rnd mul");
            end else begin
                ref_op(c, rsh, ra, rb, rs, er, eil);
                single(c, rsh, ra, rb, rs, er, eil, "rnd op");
            end
        end
        mul_seq(32'($urandom), 32'($urandom), -1, "rnd mul2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
